regfile_param: RTL and testbench
================================

REGFILE_PARAM -- requirements
Module: regfile_param

Interface
REQ-001 Parameter DATA_W, default 32, width of each register and data port.
REQ-002 Parameter ADDR_W, default 5, register index width; DEPTH = 2**ADDR_W registers.
REQ-003 Parameter BYPASS, default 1, 1 = same-cycle write-to-read forwarding enabled.
REQ-004 clock  input  1  sole clock, all state rising-edge.
REQ-005 ctrl_reset  input  1  reset; asynchronous, active-high.
REQ-006 ctrl_writeEnable  input  1  write strobe.
REQ-007 ctrl_writeReg  input  ADDR_W  write index.
REQ-008 data_writeReg  input  DATA_W  write data.
REQ-009 ctrl_readRegA / ctrl_readRegB  input  ADDR_W  read indices, ports A and B.
REQ-010 data_readRegA / data_readRegB  output  DATA_W  read data, ports A and B.
REQ-011 ctrl_reserve  input  1  mark ctrl_reserveReg pending (producer in flight).
REQ-012 ctrl_reserveReg  input  ADDR_W  index to reserve.
REQ-013 pend_readRegA / pend_readRegB  output  1  pending bit of the register addressed by ctrl_readRegA / ctrl_readRegB.
REQ-014 ctrl_clearReq  input  1  request a sequenced clear of all registers.
REQ-015 clear_busy  output  1  high while clear sweep runs.

Function
REQ-016 Register 0 SHALL read as zero, never be written, never be pending.
REQ-017 Writes SHALL commit at the rising edge when ctrl_writeEnable=1, ctrl_writeReg!=0, clear_busy=0; writes while clear_busy=1 SHALL be dropped.
REQ-018 Reads SHALL be combinational from stored contents (zero-cycle latency).
REQ-019 With BYPASS=1, clear_busy=0, ctrl_writeEnable=1, read index == ctrl_writeReg != 0: read port SHALL return data_writeReg; with BYPASS=0 it SHALL return the old value until the edge.
REQ-020 Both read ports SHALL be independent; identical indices return identical data.
REQ-021 Pending bit SHALL set at the edge when ctrl_reserve=1, ctrl_reserveReg!=0, clear_busy=0.
REQ-022 Pending bit SHALL clear at the edge on a committed write to that register.
REQ-023 Simultaneous reserve and committed write to the same register: pending SHALL remain set (reserve wins); data SHALL still commit.
REQ-024 pend_readRegA/B SHALL be combinational from stored pending bits (no bypass).
REQ-025 Clear FSM states: IDLE, SWEEP. IDLE->SWEEP on ctrl_clearReq=1 at edge; clear counter loads 1, all pending bits clear at that edge.
REQ-026 In SWEEP, each edge SHALL zero register[counter] and increment counter; at counter==DEPTH-1 that register is zeroed and state returns to IDLE.
REQ-027 Sweep SHALL take DEPTH-1 cycles; clear_busy=1 exactly in SWEEP.
REQ-028 ctrl_clearReq while in SWEEP SHALL be ignored (no restart); reserves in SWEEP dropped.
REQ-029 Reads during SWEEP SHALL return current stored contents (cleared or not); pend outputs 0.
REQ-030 Counter SHALL be ADDR_W wide; no wrap beyond DEPTH-1.

Reset
REQ-031 ctrl_reset=1 SHALL immediately (asynchronously) zero all registers, all pending bits, counter, state=IDLE, clear_busy=0.
REQ-032 Reset asserted mid-SWEEP SHALL abort the sweep; outputs per REQ-031 while held.
REQ-033 First write after reset deassertion SHALL commit on the first rising edge.

Verification
REQ-034 Write 0xDEADBEEF to r5, read A=5 next cycle -> 0xDEADBEEF; write 0x1234 to r0, read A=0 -> 0.
REQ-035 BYPASS=1: r7=0x1, same cycle write r7=0x2, read B=7 -> 0x2 before edge; BYPASS=0 -> 0x1 before edge, 0x2 after.
REQ-036 Reserve r3, read A=3 -> pend_readRegA=1; write r3 -> pend 0 next cycle; reserve+write r3 same edge -> pend stays 1, data updated.
REQ-037 Fill r1..r31 with index values, pulse ctrl_clearReq -> clear_busy high 31 cycles, write to r9 during sweep dropped, all reads 0 after.
REQ-038 Reset asserted mid-sweep and mid-cycle -> clear_busy, all pend, all data 0 without waiting for clock edge.
REQ-039 ADDR_W=3, DATA_W=16: sweep lasts 7 cycles, r7 writable and clearable, r0 reads 0.

Source files
------------

// File: rtl/regfile_param.sv
// Parameterised register file with two combinational read ports, optional write forwarding,
// per-register pending (scoreboard) bits and a sequenced clear sweep.
module regfile_param #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int BYPASS = 1
) (
    input  logic              clock,
    input  logic              ctrl_reset,
    input  logic              ctrl_writeEnable,
    input  logic [ADDR_W-1:0] ctrl_writeReg,
    input  logic [DATA_W-1:0] data_writeReg,
    input  logic [ADDR_W-1:0] ctrl_readRegA,
    input  logic [ADDR_W-1:0] ctrl_readRegB,
    output logic [DATA_W-1:0] data_readRegA,
    output logic [DATA_W-1:0] data_readRegB,
    input  logic              ctrl_reserve,
    input  logic [ADDR_W-1:0] ctrl_reserveReg,
    output logic              pend_readRegA,
    output logic              pend_readRegB,
    input  logic              ctrl_clearReq,
    output logic              clear_busy
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = '1;

    typedef enum logic {IDLE, SWEEP} state_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] counter;
    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  pend;

    logic wr_commit, res_commit, start_clear;
    logic byp_a, byp_b;

    assign clear_busy  = (state == SWEEP);
    assign start_clear = (state == IDLE) && ctrl_clearReq;
    assign wr_commit   = ctrl_writeEnable && (ctrl_writeReg != '0) && !clear_busy;
    assign res_commit  = ctrl_reserve && (ctrl_reserveReg != '0) && !clear_busy;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) state <= IDLE;
        else            state <= state_next;
    end

    // NOTE: default assigned first so no path leaves state_next unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (ctrl_clearReq) state_next = SWEEP;
            SWEEP:   if (counter == LAST_IDX) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset)
            counter <= '0;
        else if (start_clear)
            counter <= ADDR_W'(1);
        else if (clear_busy)
            counter <= (counter == LAST_IDX) ? '0 : counter + ADDR_W'(1);
    end

    // NOTE: the array is reset on purpose: an asserted reset must zero every register at once,
    // which rules out a RAM macro; register 0 relies on this reset and is never written afterwards.
    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else if (clear_busy) begin
            regs[counter] <= '0;
        end else if (wr_commit) begin
            regs[ctrl_writeReg] <= data_writeReg;
        end
    end

    // Reserve is applied after the write-clear so a same-edge reserve keeps the bit set.
    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            pend <= '0;
        end else if (start_clear) begin
            pend <= '0;
        end else begin
            if (wr_commit)  pend[ctrl_writeReg]   <= 1'b0;
            if (res_commit) pend[ctrl_reserveReg] <= 1'b1;
        end
    end

    assign byp_a = (BYPASS != 0) && wr_commit && (ctrl_readRegA == ctrl_writeReg);
    assign byp_b = (BYPASS != 0) && wr_commit && (ctrl_readRegB == ctrl_writeReg);

    assign data_readRegA = byp_a ? data_writeReg : regs[ctrl_readRegA];
    assign data_readRegB = byp_b ? data_writeReg : regs[ctrl_readRegB];

    // Pending bits are zero throughout a sweep, so these need no explicit masking.
    assign pend_readRegA = pend[ctrl_readRegA];
    assign pend_readRegB = pend[ctrl_readRegB];

endmodule

// File: tb/tb_regfile_param.sv
// Randomised and directed bench for regfile_param against a queue/array reference model;
// covers forwarding on and off and a small ADDR_W=3 / DATA_W=16 instance.
module tb_regfile_param;

    logic        clock;
    logic        rst;
    logic        we, res, clr;
    logic [4:0]  wr, ra, rb, rr;
    logic [31:0] wd;
    logic [31:0] rd_a, rd_b, nb_rd_a, nb_rd_b;
    logic        pend_a, pend_b, busy, nb_pend_a, nb_pend_b, nb_busy;

    logic        s_we, s_res, s_clr;
    logic [2:0]  s_wr, s_ra, s_rb, s_rr;
    logic [15:0] s_wd, s_rd_a, s_rd_b;
    logic        s_pend_a, s_pend_b, s_busy;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_mem [32];
    bit          m_pend [32];
    int          sweep_q [$];

    regfile_param #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) dut (
        .clock(clock), .ctrl_reset(rst),
        .ctrl_writeEnable(we), .ctrl_writeReg(wr), .data_writeReg(wd),
        .ctrl_readRegA(ra), .ctrl_readRegB(rb),
        .data_readRegA(rd_a), .data_readRegB(rd_b),
        .ctrl_reserve(res), .ctrl_reserveReg(rr),
        .pend_readRegA(pend_a), .pend_readRegB(pend_b),
        .ctrl_clearReq(clr), .clear_busy(busy)
    );

    regfile_param #(.DATA_W(32), .ADDR_W(5), .BYPASS(0)) dut_nb (
        .clock(clock), .ctrl_reset(rst),
        .ctrl_writeEnable(we), .ctrl_writeReg(wr), .data_writeReg(wd),
        .ctrl_readRegA(ra), .ctrl_readRegB(rb),
        .data_readRegA(nb_rd_a), .data_readRegB(nb_rd_b),
        .ctrl_reserve(res), .ctrl_reserveReg(rr),
        .pend_readRegA(nb_pend_a), .pend_readRegB(nb_pend_b),
        .ctrl_clearReq(clr), .clear_busy(nb_busy)
    );

    regfile_param #(.DATA_W(16), .ADDR_W(3), .BYPASS(1)) dut_small (
        .clock(clock), .ctrl_reset(rst),
        .ctrl_writeEnable(s_we), .ctrl_writeReg(s_wr), .data_writeReg(s_wd),
        .ctrl_readRegA(s_ra), .ctrl_readRegB(s_rb),
        .data_readRegA(s_rd_a), .data_readRegB(s_rd_b),
        .ctrl_reserve(s_res), .ctrl_reserveReg(s_rr),
        .pend_readRegA(s_pend_a), .pend_readRegB(s_pend_b),
        .ctrl_clearReq(s_clr), .clear_busy(s_busy)
    );

    initial clock = 1'b0;
    always #10 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit m_busy();
        return sweep_q.size() != 0;
    endfunction

    function automatic logic [31:0] exp_read(input logic [4:0] idx, input bit byp);
        if (byp && !m_busy() && we && wr != 0 && wr == idx) return wd;
        return m_mem[idx];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_mem[i]  = '0;
            m_pend[i] = 1'b0;
        end
        sweep_q.delete();
    endtask

    // Applies the architectural effect of one rising edge with the inputs currently driven.
    task automatic model_edge();
        if (m_busy()) begin
            m_mem[sweep_q.pop_front()] = '0;
        end else begin
            if (we && wr != 0) begin
                m_mem[wr]  = wd;
                m_pend[wr] = 1'b0;
            end
            if (res && rr != 0) m_pend[rr] = 1'b1;
            if (clr) begin
                for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
                for (int i = 1; i < 32; i++) sweep_q.push_back(i);
            end
        end
    endtask

    task automatic compare();
        check("busy",    {63'd0, busy},    {63'd0, m_busy()});
        check("nb_busy", {63'd0, nb_busy}, {63'd0, m_busy()});
        check("rd_a",    {32'd0, rd_a},    {32'd0, exp_read(ra, 1'b1)});
        check("rd_b",    {32'd0, rd_b},    {32'd0, exp_read(rb, 1'b1)});
        check("nb_rd_a", {32'd0, nb_rd_a}, {32'd0, exp_read(ra, 1'b0)});
        check("nb_rd_b", {32'd0, nb_rd_b}, {32'd0, exp_read(rb, 1'b0)});
        check("pend_a",  {63'd0, pend_a},  {63'd0, m_pend[ra]});
        check("pend_b",  {63'd0, pend_b},  {63'd0, m_pend[rb]});
    endtask

    task automatic step();
        #2 compare();
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        we = 0; wr = 0; wd = 0; ra = 0; rb = 0; res = 0; rr = 0; clr = 0;
    endtask

    initial begin
        int cnt;
        rst = 1'b1;
        idle_inputs();
        s_we = 0; s_wr = 0; s_wd = 0; s_ra = 0; s_rb = 0; s_res = 0; s_rr = 0; s_clr = 0;
        model_reset();
        #15;
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_rd",   {32'd0, rd_a}, 64'd0);
        rst = 1'b0;
        @(posedge clock); #1;

        // first write after reset, then r0 write ignored
        we = 1; wr = 5; wd = 32'hDEADBEEF; step();
        we = 0; ra = 5; #1 check("r5_read", {32'd0, rd_a}, 64'hDEADBEEF);
        we = 1; wr = 0; wd = 32'h1234; step();
        we = 0; ra = 0; #1 check("r0_read", {32'd0, rd_a}, 64'd0);
        step();

        // forwarding
        we = 1; wr = 7; wd = 32'h1; step();
        wd = 32'h2; rb = 7;
        #1 check("bypass_on",  {32'd0, rd_b},    64'h2);
        check("bypass_off", {32'd0, nb_rd_b}, 64'h1);
        step();
        we = 0;
        #1 check("bypass_off_after", {32'd0, nb_rd_b}, 64'h2);
        step();

        // pending bits
        res = 1; rr = 3; step();
        res = 0; ra = 3; #1 check("pend_set", {63'd0, pend_a}, 64'd1);
        we = 1; wr = 3; wd = 32'h33; step();
        we = 0; #1 check("pend_clr", {63'd0, pend_a}, 64'd0);
        res = 1; rr = 3; we = 1; wr = 3; wd = 32'h44; step();
        idle_inputs(); ra = 3;
        #1 check("pend_reserve_wins", {63'd0, pend_a}, 64'd1);
        check("data_with_reserve", {32'd0, rd_a}, 64'h44);
        step();

        // fill, sweep, dropped write and ignored re-request
        for (int i = 1; i < 32; i++) begin
            we = 1; wr = 5'(i); wd = 32'(i); step();
        end
        idle_inputs(); clr = 1; step();
        clr = 0; cnt = 0;
        while (busy && cnt < 40) begin
            cnt++;
            we  = (cnt == 3);  wr = 9; wd = 32'h99;
            clr = (cnt == 5);
            res = (cnt == 6);  rr = 4;
            ra  = 5'($urandom); rb = 5'($urandom);
            step();
        end
        idle_inputs();
        check("sweep_cycles", 64'(cnt), 64'd31);
        for (int i = 0; i < 32; i++) begin
            ra = 5'(i); rb = 5'(i);
            #1 check("post_sweep_a", {32'd0, rd_a}, 64'd0);
            check("post_sweep_pend", {63'd0, pend_b}, 64'd0);
        end
        step();

        // randomised traffic
        for (int n = 0; n < 2000; n++) begin
            we  = 1'($urandom);
            wr  = 5'($urandom);
            wd  = $urandom;
            ra  = ($urandom_range(3) == 0) ? wr : 5'($urandom);
            rb  = ($urandom_range(3) == 0) ? wr : 5'($urandom);
            res = ($urandom_range(2) == 0);
            rr  = ($urandom_range(3) == 0) ? wr : 5'($urandom);
            clr = ($urandom_range(149) == 0);
            step();
        end
        while (m_busy()) begin
            idle_inputs(); step();
        end

        // asynchronous reset mid-cycle with pending bits set
        idle_inputs();
        for (int i = 1; i < 32; i++) begin
            we = 1; wr = 5'(i); wd = 32'hA000 + 32'(i); res = 1; rr = 5'(32 - i); step();
        end
        idle_inputs();
        #3 rst = 1'b1;
        #1 model_reset();
        for (int i = 0; i < 32; i++) begin
            ra = 5'(i);
            #1 check("rst_rd", {32'd0, rd_a}, 64'd0);
            check("rst_pend", {63'd0, pend_a}, 64'd0);
        end
        #1 rst = 1'b0;
        @(posedge clock); #1;

        // asynchronous reset mid-sweep
        for (int i = 1; i < 8; i++) begin
            we = 1; wr = 5'(i + 20); wd = 32'hB0 + 32'(i); step();
        end
        idle_inputs(); clr = 1; step();
        clr = 0; step(); step();
        #3 rst = 1'b1;
        #1 model_reset();
        check("rst_sweep_busy", {63'd0, busy}, 64'd0);
        for (int i = 0; i < 32; i++) begin
            ra = 5'(i);
            #1 check("rst_sweep_rd", {32'd0, rd_a}, 64'd0);
        end
        #1 rst = 1'b0;
        we = 1; wr = 4; wd = 32'hFACE; step();
        we = 0; ra = 4; #1 check("first_write_after_rst", {32'd0, rd_a}, 64'hFACE);
        step();
        check("still_idle", {63'd0, busy}, 64'd0);

        // small instance: ADDR_W=3, DATA_W=16
        idle_inputs();
        for (int i = 0; i < 8; i++) begin
            s_we = 1; s_wr = 3'(i); s_wd = 16'h100 + 16'(i);
            @(posedge clock); #1;
        end
        s_we = 0; s_ra = 7; s_rb = 0;
        #1 check("small_r7", {48'd0, s_rd_a}, 64'h107);
        check("small_r0", {48'd0, s_rd_b}, 64'd0);
        s_clr = 1; @(posedge clock); #1;
        s_clr = 0; cnt = 0;
        while (s_busy && cnt < 20) begin
            cnt++;
            @(posedge clock); #1;
        end
        check("small_sweep_cycles", 64'(cnt), 64'd7);
        check("small_r7_cleared", {48'd0, s_rd_a}, 64'd0);
        for (int i = 0; i < 8; i++) begin
            s_rb = 3'(i);
            #1 check("small_cleared", {48'd0, s_rd_b}, 64'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
